// File: rtl/tinyriscv_pkg.sv
// Shared types and defaults for the pipeline controller: FSM state encoding,
// default flush length and bus-hold timeout, and counter widths.
package tinyriscv_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } pipe_state_e;

  localparam int unsigned FLUSH_CYCLES_DEF = 2;
  localparam int unsigned HOLD_MAX_DEF     = 255;
  localparam int unsigned FLUSH_CW         = 3;
  localparam int unsigned HOLD_CW          = 16;

endpackage

// File: rtl/gen_en_dff.sv
// Generic enabled register with asynchronous active-low reset to zero.
module gen_en_dff #(
  parameter int unsigned DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);

  logic [DW-1:0] data_q;

  // Capture d_i only when enabled; hold otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: drives PC / pipeline-register enables and
// flush strobes from jump, stall, bus-hold and (optionally) debug-halt
// requests, and flags prolonged bus holds.
// Optional feature: define PIPE_CTRL_HALT_EN to make halt_req_i enter HALT.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | normal flow, all enables high
// ST_STALL | a stall input was seen; enables follow the stall inputs
// ST_FLUSH | loading NOPs after a redirect; counter frozen while stalled
// ST_HALT  | debug halt, whole pipe frozen
module pipe_ctrl
  import tinyriscv_pkg::*;
#(
  parameter int unsigned AW           = 32,
  parameter int unsigned FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int unsigned HOLD_MAX     = HOLD_MAX_DEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          jump_req_i,
  input  logic [AW-1:0] jump_addr_i,
  input  logic          ex_stall_i,
  input  logic          bus_hold_i,
  input  logic          halt_req_i,
  output logic          en_pc_o,
  output logic          en_if_id_o,
  output logic          en_id_ex_o,
  output logic          flush_if_id_o,
  output logic          flush_id_ex_o,
  output logic          pc_jump_o,
  output logic [AW-1:0] pc_jump_addr_o,
  output logic [1:0]    state_o,
  output logic          hold_timeout_o
);

  localparam logic [FLUSH_CW-1:0] FLUSH_LD = FLUSH_CW'(FLUSH_CYCLES);
  localparam logic [HOLD_CW-1:0]  HOLD_LIM = HOLD_CW'(HOLD_MAX);
  localparam logic [HOLD_CW-1:0]  HOLD_SAT = '1;

  pipe_state_e         state_q, state_d;
  logic [FLUSH_CW-1:0] flush_cnt_q, flush_cnt_d;
  logic [HOLD_CW-1:0]  hold_cnt_q, hold_cnt_d;
  logic                timeout_q, timeout_d;
  logic                pc_jump_q;
  logic                stall_any;
  logic                halt_act;
  logic                run_ok;

`ifdef PIPE_CTRL_HALT_EN
  assign halt_act = halt_req_i;
`else
  logic unused_halt;
  assign unused_halt = halt_req_i;
  assign halt_act    = 1'b0;
`endif

  assign stall_any = bus_hold_i | ex_stall_i;

  // Next-state decode; a jump overrides everything. A halt seen while
  // flushing waits until the flush completes so no wrong-path op survives.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    if (jump_req_i) begin
      state_d     = ST_FLUSH;
      flush_cnt_d = FLUSH_LD;
    end else begin
      case (state_q)
        ST_FLUSH: begin
          if (!stall_any) begin
            if (flush_cnt_q <= FLUSH_CW'(1)) begin
              state_d     = ST_RUN;
              flush_cnt_d = '0;
            end else begin
              flush_cnt_d = flush_cnt_q - FLUSH_CW'(1);
            end
          end
        end
        ST_HALT: begin
          if (!halt_act) state_d = ST_RUN;
        end
        default: begin
          if (halt_act)       state_d = ST_HALT;
          else if (stall_any) state_d = ST_STALL;
          else                state_d = ST_RUN;
        end
      endcase
    end
  end

  // Saturating bus-hold counter and sticky timeout.
  always_comb begin
    hold_cnt_d = '0;
    if (bus_hold_i) begin
      hold_cnt_d = (hold_cnt_q == HOLD_SAT) ? hold_cnt_q : hold_cnt_q + HOLD_CW'(1);
    end
    timeout_d = timeout_q | (hold_cnt_d >= HOLD_LIM);
  end

  // State, counters and the one-cycle redirect pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
      hold_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      pc_jump_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      timeout_q   <= timeout_d;
      pc_jump_q   <= jump_req_i;
    end
  end

  gen_en_dff #(
    .DW(AW)
  ) u_jump_addr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (jump_req_i),
    .d_i    (jump_addr_i),
    .q_o    (pc_jump_addr_o)
  );

  // Enables drop combinationally on any stall and stay low in HALT; both
  // enables and flushes are held low while reset is asserted.
  assign run_ok         = rst_ni & (state_q != ST_HALT) & ~stall_any;
  assign en_pc_o        = run_ok;
  assign en_if_id_o     = run_ok;
  assign en_id_ex_o     = run_ok;
  assign flush_if_id_o  = rst_ni & (state_q == ST_FLUSH);
  assign flush_id_ex_o  = rst_ni & (state_q == ST_FLUSH);
  assign pc_jump_o      = pc_jump_q;
  assign state_o        = state_q;
  assign hold_timeout_o = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl (FLUSH_CYCLES=2, HOLD_MAX=4).
module tb_pipe_ctrl;

  localparam int AW      = 32;
  localparam int FLUSH_N = 2;
  localparam int HMAX    = 4;
`ifdef PIPE_CTRL_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          jump_req = 1'b0;
  logic [AW-1:0] jump_addr = '0;
  logic          ex_stall = 1'b0;
  logic          bus_hold = 1'b0;
  logic          halt_req = 1'b0;
  logic          en_pc, en_if_id, en_id_ex, fl_if_id, fl_id_ex, pc_jump, timeout;
  logic [AW-1:0] pc_jump_addr;
  logic [1:0]    state;

  int n_chk = 0;
  int n_err = 0;

  pipe_ctrl #(.AW(AW), .FLUSH_CYCLES(FLUSH_N), .HOLD_MAX(HMAX)) dut (
    .clk_i(clk), .rst_ni(rst_n), .jump_req_i(jump_req), .jump_addr_i(jump_addr),
    .ex_stall_i(ex_stall), .bus_hold_i(bus_hold), .halt_req_i(halt_req),
    .en_pc_o(en_pc), .en_if_id_o(en_if_id), .en_id_ex_o(en_id_ex),
    .flush_if_id_o(fl_if_id), .flush_id_ex_o(fl_id_ex),
    .pc_jump_o(pc_jump), .pc_jump_addr_o(pc_jump_addr),
    .state_o(state), .hold_timeout_o(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: what the pipe is doing, in terms of remaining flush
  // cycles, halt/stall status and consecutive hold cycles.
  typedef struct {
    int            flush_left;
    int            hold_run;
    bit            halted;
    bit            stalled;
    bit            pulse;
    bit            tmo;
    logic [AW-1:0] addr;
  } model_t;

  model_t m;

  function automatic model_t step(model_t c, bit j, logic [AW-1:0] a, bit ex, bit bh, bit h);
    model_t n = c;
    bit busy = ex | bh;
    n.pulse = j;
    if (j) begin
      n.addr = a;
      n.flush_left = FLUSH_N;
      n.halted = 0;
      n.stalled = 0;
    end else if (c.flush_left > 0) begin
      if (!busy) n.flush_left = c.flush_left - 1;
    end else if (c.halted) begin
      n.halted = HALT_EN && h;
    end else begin
      n.halted = HALT_EN && h;
      n.stalled = !n.halted && busy;
    end
    if (bh) n.hold_run = (c.hold_run < 65535) ? c.hold_run + 1 : c.hold_run;
    else n.hold_run = 0;
    if (n.hold_run >= HMAX) n.tmo = 1;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{flush_left: 0, hold_run: 0, halted: 0, stalled: 0, pulse: 0, tmo: 0, addr: '0};
    else m <= step(m, jump_req, jump_addr, ex_stall, bus_hold, halt_req);
  end

  // Compare every output against the model on every falling edge.
  always @(negedge clk) begin
    logic          e_en, e_fl;
    logic [1:0]    e_st;
    e_en = rst_n && !m.halted && !(ex_stall || bus_hold);
    e_fl = rst_n && (m.flush_left > 0);
    e_st = (m.flush_left > 0) ? 2'd2 : m.halted ? 2'd3 : m.stalled ? 2'd1 : 2'd0;
    chk("m_en_pc", en_pc, e_en);
    chk("m_en_if_id", en_if_id, e_en);
    chk("m_en_id_ex", en_id_ex, e_en);
    chk("m_flush_if_id", fl_if_id, e_fl);
    chk("m_flush_id_ex", fl_id_ex, e_fl);
    chk("m_state", state, e_st);
    chk("m_pc_jump", pc_jump, m.pulse);
    chk("m_pc_jump_addr", pc_jump_addr, m.addr);
    chk("m_timeout", timeout, m.tmo);
  end

  initial begin
    int n, tot, unst;
    #3;
    chk("rst_en", en_pc, 0);
    chk("rst_flush", fl_if_id, 0);
    chk("rst_state", state, 0);
    chk("rst_pc_jump", pc_jump, 0);
    #9 rst_n = 1'b1;
    tick(); tick();
    @(negedge clk);
    chk("idle_en", en_pc, 1);
    chk("idle_flush", fl_id_ex, 0);
    tick();

    // Single jump to 0x100
    jump_req = 1; jump_addr = 32'h0000_0100;
    @(negedge clk); chk("j_pre_state", state, 0);
    tick(); jump_req = 0;
    @(negedge clk);
    chk("j_pulse", pc_jump, 1); chk("j_addr", pc_jump_addr, 32'h100);
    chk("j_flush1", fl_if_id, 1); chk("j_state1", state, 2);
    tick();
    @(negedge clk);
    chk("j_pulse_gone", pc_jump, 0); chk("j_flush2", fl_id_ex, 1); chk("j_state2", state, 2);
    tick();
    @(negedge clk);
    chk("j_flush_end", fl_if_id, 0); chk("j_run", state, 0); chk("j_en", en_if_id, 1);
    tick();

    // ex_stall for 5 cycles
    ex_stall = 1; n = 0;
    repeat (5) begin
      @(negedge clk);
      if (!en_pc && !en_if_id && !en_id_ex && !fl_if_id && !fl_id_ex) n++;
      tick();
    end
    ex_stall = 0;
    @(negedge clk); chk("st_still_stall", state, 1); chk("st_en_back", en_pc, 1);
    tick();
    @(negedge clk); chk("st_run", state, 0); chk("st_low_cycles", n, 5);
    tick();

    // jump and bus_hold together, hold for 3 cycles total
    jump_req = 1; jump_addr = 32'h0000_0200; bus_hold = 1;
    @(negedge clk); chk("jh_en_low", en_id_ex, 0);
    tick(); jump_req = 0;
    tot = 0; unst = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) bus_hold = 0;
      @(negedge clk);
      if (fl_if_id) begin tot++; if (!bus_hold) unst++; end
      tick();
    end
    chk("jh_flush_total", tot, 4); chk("jh_flush_unstalled", unst, 2);
    chk("jh_addr", pc_jump_addr, 32'h200); chk("jh_no_timeout", timeout, 0);

    // jump during FLUSH restarts it with the new address
    jump_req = 1; jump_addr = 32'h0000_0400;
    tick(); jump_addr = 32'h0000_0500;
    tick(); jump_req = 0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) begin chk("jj_addr", pc_jump_addr, 32'h500); chk("jj_pulse", pc_jump, 1); end
      if (fl_if_id) n++;
      tick();
    end
    chk("jj_flush_cycles", n, 2);

    // bus hold for longer than HOLD_MAX
    bus_hold = 1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      @(negedge clk);
      chk("hold_timeout", timeout, (i >= 4) ? 1 : 0);
    end
    tick(); bus_hold = 0;
    tick(); tick();
    @(negedge clk); chk("timeout_sticky", timeout, 1);
    tick();

    // reset in the first FLUSH cycle
    jump_req = 1; jump_addr = 32'h0000_0300;
    tick(); jump_req = 0;
    #3 rst_n = 1'b0;
    #1;
    chk("ar_en", en_pc, 0); chk("ar_flush", fl_if_id, 0); chk("ar_state", state, 0);
    chk("ar_pulse", pc_jump, 0); chk("ar_addr", pc_jump_addr, 0); chk("ar_timeout", timeout, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    n = 0;
    repeat (5) begin
      tick();
      @(negedge clk);
      if (fl_if_id || fl_id_ex || pc_jump) n++;
    end
    chk("ar_no_residue", n, 0);
    tick();

    // debug halt for 3 cycles
    halt_req = 1;
    tick();
    @(negedge clk); chk("h_state1", state, HALT_EN ? 3 : 0); chk("h_en1", en_pc, HALT_EN ? 0 : 1);
    tick();
    @(negedge clk); chk("h_state2", state, HALT_EN ? 3 : 0); chk("h_en2", en_id_ex, HALT_EN ? 0 : 1);
    tick(); halt_req = 0;
    @(negedge clk); chk("h_state3", state, HALT_EN ? 3 : 0);
    tick();
    @(negedge clk); chk("h_release", state, 0); chk("h_en_back", en_if_id, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
